bicubic_wvec_pmat_pipe: RTL



---
 rtl/bicubic_wvec_pmat_pipe_if.sv | 28 ++
 rtl/bicubic_wvec_pmat_pipe.sv | 138 +++++++++++++
 2 files changed

// File: rtl/bicubic_wvec_pmat_pipe_if.sv
// Handshake and payload bundle for the weight-vector x pixel-matrix pipeline.
// The master drives input payload and out_ready; the slave is the datapath.
interface bicubic_wvec_pmat_pipe_if #(
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned WEIGHT_WIDTH  = 3,
  parameter int unsigned TAPS          = 4,
  parameter int unsigned ROWS          = 4,
  parameter int unsigned PRODUCT_WIDTH = 24
);
  logic                                          in_valid;
  logic                                          in_ready;
  logic                                          clamp_en;
  logic [TAPS*WEIGHT_WIDTH-1:0]                  weights;
  logic [ROWS*TAPS*(CHANNEL_WIDTH+1)-1:0]        pixels;
  logic                                          out_valid;
  logic                                          out_ready;
  logic [ROWS*PRODUCT_WIDTH-1:0]                 inner_products;

  modport master (
    output in_valid, clamp_en, weights, pixels, out_ready,
    input  in_ready, out_valid, inner_products
  );

  modport slave (
    input  in_valid, clamp_en, weights, pixels, out_ready,
    output in_ready, out_valid, inner_products
  );
endinterface

// File: rtl/bicubic_wvec_pmat_pipe.sv
// Three-stage valid/ready pipeline: ROWS signed inner products of a TAPS weight
// vector against each pixel row, with optional round-shift-clamp to pixel range.
module bicubic_wvec_pmat_pipe #(
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned WEIGHT_WIDTH  = 3,
  parameter int unsigned TAPS          = 4,
  parameter int unsigned ROWS          = 4,
  parameter int unsigned PRODUCT_WIDTH = 24,
  parameter int unsigned SHIFT         = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  bicubic_wvec_pmat_pipe_if.slave      bus
);
  localparam int unsigned PIX_W     = CHANNEL_WIDTH + 1;
  localparam int unsigned MUL_W     = WEIGHT_WIDTH + PIX_W;
  localparam int unsigned PAIR_W    = MUL_W + 1;
  localparam int unsigned SUM_W     = MUL_W + $clog2(TAPS);
  localparam int unsigned RND_W     = SUM_W + 1;
  localparam int unsigned HALF_TAPS = TAPS / 2;
  localparam int unsigned NPROD     = ROWS * TAPS;
  localparam int unsigned NPAIR     = ROWS * HALF_TAPS;

  localparam logic signed [RND_W-1:0] HALF_C = RND_W'(2 ** (SHIFT - 1));
  localparam logic signed [RND_W-1:0] MAXV_C = RND_W'(2 ** CHANNEL_WIDTH - 1);

  logic adv1, adv2, adv3;

  logic                       s1_valid_q;
  logic                       s1_clamp_q;
  logic signed [MUL_W-1:0]    s1_prod_q [NPROD];
  logic signed [MUL_W-1:0]    s1_prod_d [NPROD];

  logic                       s2_valid_q;
  logic                       s2_clamp_q;
  logic signed [PAIR_W-1:0]   s2_pair_q [NPAIR];
  logic signed [PAIR_W-1:0]   s2_pair_d [NPAIR];

  logic                       s3_valid_q;
  logic [ROWS*PRODUCT_WIDTH-1:0] s3_out_q;
  logic [ROWS*PRODUCT_WIDTH-1:0] s3_out_d;

  logic signed [SUM_W-1:0]    row_sum;
  logic signed [RND_W-1:0]    row_rnd;
  logic signed [RND_W-1:0]    row_shr;
  logic [CHANNEL_WIDTH-1:0]   row_pix;

  // Each stage refills whenever it is empty, so bubbles collapse under stall.
  assign adv3 = !s3_valid_q || bus.out_ready;
  assign adv2 = !s2_valid_q || adv3;
  assign adv1 = !s1_valid_q || adv2;

  assign bus.in_ready       = adv1;
  assign bus.out_valid      = s3_valid_q;
  assign bus.inner_products = s3_out_q;

  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned t = 0; t < TAPS; t++) begin
        s1_prod_d[r*TAPS+t] =
          MUL_W'($signed(bus.weights[t*WEIGHT_WIDTH +: WEIGHT_WIDTH])) *
          MUL_W'($signed(bus.pixels[(r*TAPS+t)*PIX_W +: PIX_W]));
      end
    end
  end

  always_comb begin
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned k = 0; k < HALF_TAPS; k++) begin
        s2_pair_d[r*HALF_TAPS+k] = PAIR_W'(s1_prod_q[r*TAPS+2*k]) +
                                   PAIR_W'(s1_prod_q[r*TAPS+2*k+1]);
      end
    end
  end

  always_comb begin
    s3_out_d = '0;
    row_sum  = '0;
    row_rnd  = '0;
    row_shr  = '0;
    row_pix  = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      row_sum = '0;
      for (int unsigned k = 0; k < HALF_TAPS; k++) begin
        row_sum = row_sum + SUM_W'(s2_pair_q[r*HALF_TAPS+k]);
      end
      row_rnd = RND_W'(row_sum) + HALF_C;
      row_shr = row_rnd >>> SHIFT;
      if (row_shr[RND_W-1]) begin
        row_pix = '0;
      end else if (row_shr > MAXV_C) begin
        row_pix = '1;
      end else begin
        row_pix = row_shr[CHANNEL_WIDTH-1:0];
      end
      if (s2_clamp_q) begin
        s3_out_d[r*PRODUCT_WIDTH +: PRODUCT_WIDTH] = PRODUCT_WIDTH'(row_pix);
      end else begin
        s3_out_d[r*PRODUCT_WIDTH +: PRODUCT_WIDTH] = PRODUCT_WIDTH'(row_sum);
      end
    end
  end

  // Payload registers load only alongside a valid token so idle X never moves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_clamp_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_clamp_q <= 1'b0;
      s3_valid_q <= 1'b0;
      s3_out_q   <= '0;
      for (int unsigned i = 0; i < NPROD; i++) s1_prod_q[i] <= '0;
      for (int unsigned i = 0; i < NPAIR; i++) s2_pair_q[i] <= '0;
    end else begin
      if (adv1) begin
        s1_valid_q <= bus.in_valid;
        if (bus.in_valid) begin
          s1_prod_q  <= s1_prod_d;
          s1_clamp_q <= bus.clamp_en;
        end
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          s2_pair_q  <= s2_pair_d;
          s2_clamp_q <= s1_clamp_q;
        end
      end
      if (adv3) begin
        s3_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          s3_out_q <= s3_out_d;
        end
      end
    end
  end
endmodule
